// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: request sequencer between the MEM pipeline stage and mem_system.
//
// Accepts one load/store from the pipeline. A misaligned request (odd byte address)
// completes without touching memory and returns an error. An aligned request
// latches its address, data and direction and issues a single-cycle Rd/Wr pulse.
// It then waits for Done and returns the read data, error and hit status with a
// one-cycle resp_valid. A watchdog aborts the wait with an error after TIMEOUT
// cycles. Saturating hit/miss counters track completed accesses.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   req_valid/wr/addr/wdata  pipeline request, held until resp_valid
//   clr_cnt                  synchronous clear of hit_cnt/miss_cnt
//   pipe_stall               hold the MEM stage while a request is outstanding
//   resp_valid/rdata/err/hit completion pulse and its payload
//   ms_addr/datain/rd/wr     request side of mem_system
//   ms_dataout/done/stall/hit/err  response side of mem_system
//   hit_cnt, miss_cnt        saturating performance counters
module mem_req_ctrl #(
   parameter int unsigned TIMEOUT = 200,
   parameter int unsigned TO_W    = 8     // must satisfy TIMEOUT < 2**TO_W
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_wr,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   input  logic        clr_cnt,
   output logic        pipe_stall,
   output logic        resp_valid,
   output logic [15:0] resp_rdata,
   output logic        resp_err,
   output logic        resp_hit,
   output logic [15:0] ms_addr,
   output logic [15:0] ms_datain,
   output logic        ms_rd,
   output logic        ms_wr,
   input  logic [15:0] ms_dataout,
   input  logic        ms_done,
   input  logic        ms_stall,
   input  logic        ms_hit,
   input  logic        ms_err,
   output logic [15:0] hit_cnt,
   output logic [15:0] miss_cnt
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   // The watchdog holds the number of WAIT cycles already spent; the current WAIT
   // cycle is the TIMEOUT-th one when it equals TIMEOUT-1.
   localparam logic [TO_W-1:0] WdLast = TO_W'(TIMEOUT - 1);

   state_e          state_q, state_d;
   logic [15:0]     addr_q, addr_d;
   logic [15:0]     wdata_q, wdata_d;
   logic            wr_q, wr_d;
   logic [15:0]     rdata_q, rdata_d;
   logic            err_q, err_d;
   logic            hit_q, hit_d;
   logic [TO_W-1:0] wd_q, wd_d;
   logic [15:0]     hit_cnt_q, hit_cnt_d;
   logic [15:0]     miss_cnt_q, miss_cnt_d;

   logic wd_expire;
   logic done_in_wait;
   logic unused_ms_stall;

   // mem_system Stall is informational only; Done alone ends the wait.
   assign unused_ms_stall = ms_stall;

   assign wd_expire    = (wd_q == WdLast);
   assign done_in_wait = (state_q == StWait) && ms_done;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               state_d = req_addr[0] ? StResp : StIssue;
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            if (ms_done || wd_expire) begin
               state_d = StResp;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath registers: holding, response capture, watchdog, counters
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         wr_q       <= 1'b0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         hit_q      <= 1'b0;
         wd_q       <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wr_q       <= wr_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         hit_q      <= hit_d;
         wd_q       <= wd_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      hit_d   = hit_q;
      wd_d    = wd_q;

      if ((state_q == StIdle) && req_valid) begin
         if (!req_addr[0]) begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            wr_d    = req_wr;
            wd_d    = '0;
         end else begin
            // Misaligned: respond with an error, no memory access.
            rdata_d = '0;
            err_d   = 1'b1;
            hit_d   = 1'b0;
         end
      end

      if (state_q == StWait) begin
         if (ms_done) begin
            rdata_d = wr_q ? 16'h0000 : ms_dataout;
            err_d   = ms_err;
            hit_d   = ms_hit;
         end else if (wd_expire) begin
            rdata_d = '0;
            err_d   = 1'b1;
            hit_d   = 1'b0;
         end else begin
            wd_d = wd_q + TO_W'(1);
         end
      end
   end

   // Counters move only on a Done seen in WAIT; clear wins over increment.
   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (clr_cnt) begin
         hit_cnt_d  = '0;
         miss_cnt_d = '0;
      end else if (done_in_wait) begin
         if (ms_hit) begin
            if (hit_cnt_q != 16'hFFFF) begin
               hit_cnt_d = hit_cnt_q + 16'd1;
            end
         end else begin
            if (miss_cnt_q != 16'hFFFF) begin
               miss_cnt_d = miss_cnt_q + 16'd1;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      // rst gating keeps every output at 0 while reset is asserted.
      pipe_stall = req_valid && !rst && (state_q != StResp);
      resp_valid = (state_q == StResp);
      ms_rd      = (state_q == StIssue) && !wr_q;
      ms_wr      = (state_q == StIssue) && wr_q;
      ms_addr    = addr_q;
      ms_datain  = wdata_q;
      resp_rdata = rdata_q;
      resp_err   = err_q;
      resp_hit   = hit_q;
      hit_cnt    = hit_cnt_q;
      miss_cnt   = miss_cnt_q;
   end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: table of requests with expected responses, a small
// mem_system model answering each issue after a per-vector delay, and a
// scoreboard queue of expected responses popped on resp_valid.
module tb_mem_req_ctrl;

   localparam int unsigned TIMEOUT = 200;
   localparam int unsigned TO_W    = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_wr, clr_cnt;
   logic [15:0] req_addr, req_wdata;
   logic        pipe_stall, resp_valid, resp_err, resp_hit;
   logic [15:0] resp_rdata, ms_addr, ms_datain;
   logic        ms_rd, ms_wr;
   logic [15:0] ms_dataout;
   logic        ms_done, ms_stall, ms_hit, ms_err;
   logic [15:0] hit_cnt, miss_cnt;

   always #5 clk = ~clk;

   mem_req_ctrl #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .clr_cnt    (clr_cnt),
      .pipe_stall (pipe_stall),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .resp_hit   (resp_hit),
      .ms_addr    (ms_addr),
      .ms_datain  (ms_datain),
      .ms_rd      (ms_rd),
      .ms_wr      (ms_wr),
      .ms_dataout (ms_dataout),
      .ms_done    (ms_done),
      .ms_stall   (ms_stall),
      .ms_hit     (ms_hit),
      .ms_err     (ms_err),
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
   );

   // dly: cycles from the ISSUE cycle to the Done cycle, 0 = Done never comes.
   // b2b: request presented in the RESP cycle of the previous one.
   // late: pulse Done again after the response. drop: lower req_valid after issue.
   // pre: preload hit_cnt to 0xFFFE before the request.
   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          dly;
      logic [15:0] dout;
      logic        mhit;
      logic        merr;
      logic        clr;
      logic        b2b;
      logic        late;
      logic        drop;
      logic        pre;
      logic [15:0] exp_rdata;
      logic        exp_err;
      logic        exp_hit;
      logic [15:0] exp_hc;
      logic [15:0] exp_mc;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      logic        hit;
      int          lat;
   } exp_t;

   localparam int NVEC = 14;
   vec_t tab[NVEC];
   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      exp_t  e, got_e;
      int    issue_c, pulses, lat;
      bit    got, stall_bad, addr_bad, kind_bad, late_bad;
      string p;
      p = $sformatf("v%0d", idx);
      if (!v.b2b) begin
         req_valid = 1'b0;
         @(negedge clk);
      end
      req_valid = 1'b1;
      req_wr    = v.wr;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      e.rdata   = v.exp_rdata;
      e.err     = v.exp_err;
      e.hit     = v.exp_hit;
      e.lat     = v.exp_lat;
      sb_q.push_back(e);
      issue_c   = -1;
      pulses    = 0;
      lat       = 0;
      got       = 1'b0;
      stall_bad = 1'b0;
      addr_bad  = 1'b0;
      kind_bad  = 1'b0;
      for (int c = 1; c <= int'(TIMEOUT) + 20 && !got; c++) begin
         @(negedge clk);
         // sample
         if (ms_rd || ms_wr) begin
            pulses++;
            issue_c = c;
            if (ms_wr !== v.wr || ms_rd !== !v.wr) kind_bad = 1'b1;
            if (v.wr && ms_datain !== v.wdata) kind_bad = 1'b1;
         end
         if (issue_c >= 0 && ms_addr !== v.addr) addr_bad = 1'b1;
         if (resp_valid) begin
            got = 1'b1;
            lat = c;
            if (pipe_stall !== 1'b0) stall_bad = 1'b1;
            if (sb_q.size() == 0) begin
               check({p, "_unexpected_resp"}, 32'(sb_q.size()), 1);
            end else begin
               got_e = sb_q.pop_front();
               check({p, "_rdata"}, resp_rdata, got_e.rdata);
               check({p, "_err"}, resp_err, got_e.err);
               check({p, "_hit"}, resp_hit, got_e.hit);
               check({p, "_latency"}, lat, got_e.lat);
               check({p, "_hit_cnt"}, hit_cnt, v.exp_hc);
               check({p, "_miss_cnt"}, miss_cnt, v.exp_mc);
            end
         end else if (pipe_stall !== req_valid) begin
            stall_bad = 1'b1;
         end
         // drive the mem_system model; off-Done values are noise
         ms_done    = 1'b0;
         clr_cnt    = 1'b0;
         ms_hit     = 1'($urandom_range(0, 1));
         ms_err     = 1'($urandom_range(0, 1));
         ms_dataout = 16'($urandom);
         if (!got && issue_c >= 0 && v.dly > 0 && c == issue_c + v.dly) begin
            ms_done    = 1'b1;
            ms_dataout = v.dout;
            ms_hit     = v.mhit;
            ms_err     = v.merr;
            clr_cnt    = v.clr;
         end
         if (v.drop && c == 1) req_valid = 1'b0;
      end
      check({p, "_resp_seen"}, got, 1);
      if (!got && sb_q.size() > 0) void'(sb_q.pop_back());
      check({p, "_issue_pulses"}, pulses, v.addr[0] ? 0 : 1);
      check({p, "_issue_kind"}, kind_bad, 0);
      check({p, "_addr_stable"}, addr_bad, 0);
      check({p, "_pipe_stall"}, stall_bad, 0);
      if (v.late) begin
         late_bad   = 1'b0;
         req_valid  = 1'b0;
         ms_done    = 1'b1;
         ms_hit     = 1'b1;
         ms_err     = 1'b0;
         ms_dataout = 16'hFFFF;
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (resp_valid || ms_rd || ms_wr) late_bad = 1'b1;
            if (k == 1) ms_done = 1'b0;
         end
         check({p, "_late_done_ignored"}, late_bad, 0);
         check({p, "_late_hit_cnt"}, hit_cnt, v.exp_hc);
         check({p, "_late_miss_cnt"}, miss_cnt, v.exp_mc);
      end
   endtask

   initial begin : main
      vec_t fin;
      bit   quiet_bad;

      //          wr   addr    wdata   dly dout    mh   me   clr  b2b  late drop pre
      //          rdata   err  hit  hit_cnt miss_cnt lat
      tab[0]  = '{1'b0, 16'h0010, 16'h0000, 3, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0001, 5};
      tab[1]  = '{1'b1, 16'h0010, 16'h1234, 2, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0002, 4};
      tab[2]  = '{1'b0, 16'h0010, 16'h0000, 1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                  1'b0, 16'h1234, 1'b0, 1'b1, 16'h0001, 16'h0002, 4};
      tab[3]  = '{1'b0, 16'h0011, 16'h0000, 1, 16'h9999, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 16'h0002, 1};
      tab[4]  = '{1'b1, 16'h00FF, 16'h4321, 1, 16'h9999, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                  1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 16'h0002, 2};
      tab[5]  = '{1'b0, 16'h0020, 16'h0000, 2, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 16'h5555, 1'b1, 1'b0, 16'h0001, 16'h0003, 4};
      tab[6]  = '{1'b0, 16'h0030, 16'h0000, 0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                  1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 16'h0003, int'(TIMEOUT) + 2};
      tab[7]  = '{1'b0, 16'h0030, 16'h0000, 1, 16'h0A0A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 16'h0A0A, 1'b0, 1'b1, 16'h0002, 16'h0003, 3};
      tab[8]  = '{1'b0, 16'h0040, 16'h0000, 1, 16'h0B0B, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                  1'b0, 16'h0B0B, 1'b0, 1'b1, 16'h0000, 16'h0000, 3};
      tab[9]  = '{1'b1, 16'h0042, 16'h7777, 1, 16'h0C0C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 16'h0000, 3};
      tab[10] = '{1'b0, 16'h0044, 16'h0000, 1, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b1, 16'h1111, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 3};
      tab[11] = '{1'b0, 16'h0046, 16'h0000, 2, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                  1'b0, 16'h2222, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 5};
      tab[12] = '{1'b0, 16'h0048, 16'h0000, 1, 16'h3333, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                  1'b0, 16'h3333, 1'b0, 1'b0, 16'h0000, 16'h0000, 3};
      tab[13] = '{1'b0, 16'h004A, 16'h0000, 1, 16'h4444, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                  1'b0, 16'h4444, 1'b0, 1'b0, 16'h0000, 16'h0001, 4};

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_wr     = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      clr_cnt    = 1'b0;
      ms_dataout = '0;
      ms_done    = 1'b0;
      ms_stall   = 1'b0;
      ms_hit     = 1'b0;
      ms_err     = 1'b0;
      #12;
      check("reset_ctrl_outs", {pipe_stall, resp_valid, resp_err, resp_hit, ms_rd, ms_wr}, 0);
      check("reset_ms_addr", ms_addr, 0);
      check("reset_counters", {hit_cnt, miss_cnt}, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         if (tab[i].pre) begin
            req_valid = 1'b0;
            @(negedge clk);
            force dut.hit_cnt_q = 16'hFFFE;
            #1;
            release dut.hit_cnt_q;
         end
         run_vec(i, tab[i]);
      end

      // Reset asserted while a store sits in WAIT: everything drops at once.
      req_valid = 1'b0;
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = 16'h0050;
      req_wdata = 16'hA5A5;
      ms_done   = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_wait_ms_addr", ms_addr, 0);
      check("rst_wait_ms_datain", ms_datain, 0);
      check("rst_wait_resp_rdata", resp_rdata, 0);
      check("rst_wait_ctrl_outs", {pipe_stall, resp_valid, resp_err, resp_hit, ms_rd, ms_wr}, 0);
      check("rst_wait_counters", {hit_cnt, miss_cnt}, 0);
      req_valid = 1'b0;
      @(negedge clk);
      rst        = 1'b0;
      ms_done    = 1'b1;
      ms_hit     = 1'b1;
      ms_dataout = 16'h5A5A;
      quiet_bad  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (resp_valid || ms_rd || ms_wr) quiet_bad = 1'b1;
         if (k == 1) ms_done = 1'b0;
      end
      check("post_rst_done_ignored", quiet_bad, 0);
      check("post_rst_counters", {hit_cnt, miss_cnt}, 0);

      fin = '{1'b0, 16'h0060, 16'h0000, 1, 16'h7070, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 16'h7070, 1'b0, 1'b1, 16'h0001, 16'h0000, 3};
      run_vec(NVEC, fin);

      check("scoreboard_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
